// File: rtl/flush_pump_pwm_gen.sv
// Flush-pump PWM generator: double-buffered period/duty applied at period
// boundaries, with an optional per-period slew limit on the applied duty.
module flush_pump_pwm_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      duty_cycle,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] ramp_step,
  input  logic             enable,
  output logic             pwm_out,
  output logic             period_start,
  output logic [CNT_W:0]   duty_applied,
  output logic             at_target
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] period_q, period_q_d;
  logic [CNT_W:0]   duty_d;
  logic             at_target_d, pwm_d, period_start_d;

  logic             boundary, load;
  logic [CNT_W:0]   duty_req, period_len, target, ramp_val;
  logic             unused_duty_bits;

  assign unused_duty_bits = ^duty_cycle[31:CNT_W];

  // Move applied toward target by at most step; widened so applied+step cannot wrap.
  function automatic logic [CNT_W:0] ramp(input logic [CNT_W:0]   applied,
                                          input logic [CNT_W:0]   tgt,
                                          input logic [CNT_W-1:0] step);
    logic [CNT_W+1:0] a, t, s, sum, diff;
    a    = {1'b0, applied};
    t    = {1'b0, tgt};
    s    = {2'b00, step};
    sum  = a + s;
    diff = a - s;
    if (step == '0)      return tgt;
    if (a < t)           return (sum > t) ? tgt : sum[CNT_W:0];
    if (a >= t + s)      return diff[CNT_W:0];
    return tgt;
  endfunction

  assign duty_req   = {1'b0, duty_cycle[CNT_W-1:0]};
  assign period_len = {1'b0, period} + {{CNT_W{1'b0}}, 1'b1};
  assign target     = (duty_req < period_len) ? duty_req : period_len;
  assign ramp_val   = ramp(duty_applied, target, ramp_step);
  assign boundary   = (state == RUN) && (cnt == period_q);
  assign load       = enable && ((state == IDLE) || boundary);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (enable)               next_state = RUN;
      RUN:  if (boundary && !enable)  next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
  end

  // Next values for the counter and every registered output, so that outputs
  // reflect the period cycle they are displayed in with no comb path to pins.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    cnt_d       = cnt + CNT_W'(1);
    period_q_d  = period_q;
    duty_d      = duty_applied;
    at_target_d = at_target;
    if (load) begin
      cnt_d       = '0;
      period_q_d  = period;
      duty_d      = ramp_val;
      at_target_d = (ramp_val == target);
    end else if ((state == IDLE) || boundary) begin
      cnt_d       = '0;
      duty_d      = '0;
      at_target_d = (target == '0);
    end
    pwm_d          = (next_state == RUN) && ({1'b0, cnt_d} < duty_d);
    period_start_d = (next_state == RUN) && (cnt_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      period_q     <= '0;
      duty_applied <= '0;
      at_target    <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_d;
      period_q     <= period_q_d;
      duty_applied <= duty_d;
      at_target    <= at_target_d;
      pwm_out      <= pwm_d;
      period_start <= period_start_d;
    end
  end

endmodule
